// File: rtl/free_list_allocator.sv
// free_list_allocator: free-bitmap pool of N_ENTRIES indices, one allocation and one return per cycle.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   flush             : synchronous restore of the pool to its reset contents
//   alloc_req         : consumer takes alloc_idx this cycle (ignored when alloc_valid=0)
//   alloc_valid/idx   : a free index is offered (idx is 0 when nothing is free)
//   free_valid/idx    : index returned to the pool
//   free_count        : registered number of free entries
//   double_free_err   : one-cycle pulse for an illegal free in the previous cycle
module free_list_allocator #(
   parameter int N_ENTRIES  = 32,
   parameter int IDX_W      = $clog2(N_ENTRIES),
   parameter int N_RESERVED = 0,
   parameter int POLICY     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             alloc_req,
   output logic             alloc_valid,
   output logic [IDX_W-1:0] alloc_idx,
   input  logic             free_valid,
   input  logic [IDX_W-1:0] free_idx,
   output logic [IDX_W:0]   free_count,
   output logic             double_free_err
);
   localparam logic [N_ENTRIES-1:0] ONE     = {{(N_ENTRIES-1){1'b0}}, 1'b1};
   localparam logic [N_ENTRIES-1:0] RST_MAP = ~((ONE << N_RESERVED) - ONE);
   localparam logic [IDX_W:0]       RST_CNT = (IDX_W+1)'(N_ENTRIES - N_RESERVED);
   localparam logic [IDX_W:0]       N_W     = (IDX_W+1)'(N_ENTRIES);
   logic [N_ENTRIES-1:0] map_q, map_d;
   logic [IDX_W-1:0]     rr_q, rr_d;
   logic [IDX_W:0]       cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 grant, in_range, legal_free;
   logic [IDX_W:0]       j;
   // Later hits overwrite earlier ones, so each policy scans toward its most preferred index last.
   // Round-robin scans from rr_ptr+N-1 down to rr_ptr (mod N), leaving the first free at/after rr_ptr.
   always_comb begin
      alloc_idx = '0;
      j         = '0;
      for (int k = 0; k < N_ENTRIES; k++) begin
         if (POLICY == 1) begin
            if (map_q[k]) alloc_idx = IDX_W'(k);
         end else begin
            j = (POLICY == 2) ? {1'b0, rr_q} + (IDX_W+1)'(N_ENTRIES-1-k) : (IDX_W+1)'(N_ENTRIES-1-k);
            j = (j >= N_W) ? j - N_W : j;
            if (map_q[j[IDX_W-1:0]]) alloc_idx = j[IDX_W-1:0];
         end
      end
   end
   assign alloc_valid = |map_q;
   assign grant       = alloc_req & alloc_valid;
   assign in_range    = {1'b0, free_idx} < N_W;
   // A free of the index granted this cycle sees its pre-edge bit still set, so it is rejected.
   assign legal_free  = free_valid & in_range & ~map_q[free_idx];
   always_comb begin
      map_d = map_q;
      if (grant) map_d[alloc_idx] = 1'b0;
      if (legal_free) map_d[free_idx] = 1'b1;
      rr_d  = (POLICY == 2 && grant) ? ((alloc_idx == IDX_W'(N_ENTRIES-1)) ? '0 : alloc_idx + IDX_W'(1)) : rr_q;
      cnt_d = cnt_q + (IDX_W+1)'(legal_free) - (IDX_W+1)'(grant);
      err_d = free_valid & ~legal_free;
      if (flush) begin
         map_d = RST_MAP;
         rr_d  = '0;
         cnt_d = RST_CNT;
         err_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_q <= RST_MAP;
         rr_q  <= '0;
         cnt_q <= RST_CNT;
         err_q <= 1'b0;
      end else begin
         map_q <= map_d;
         rr_q  <= rr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign free_count      = cnt_q;
   assign double_free_err = err_q;
endmodule

// File: tb/tb_free_list_allocator.sv
// tb_free_list_allocator: three allocator configurations checked against a bitmap reference model.
module tb_free_list_allocator;
   typedef struct {
      bit [255:0] map;
      int         rr;
      bit         err;
   } mdl_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic fl [3];
   logic rq [3];
   logic fv [3];
   logic [7:0] fi [3];
   logic av0, av1, av2, er0, er1, er2;
   logic [4:0] ai0;
   logic [2:0] ai1;
   logic [3:0] ai2;
   logic [5:0] fc0;
   logic [3:0] fc1;
   logic [4:0] fc2;
   mdl_t m [3];
   int n_tests = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   free_list_allocator #(.N_ENTRIES(32), .N_RESERVED(8), .POLICY(0)) u_lo (
      .clk(clk), .rst_n(rst_n), .flush(fl[0]), .alloc_req(rq[0]), .alloc_valid(av0), .alloc_idx(ai0),
      .free_valid(fv[0]), .free_idx(fi[0][4:0]), .free_count(fc0), .double_free_err(er0));
   free_list_allocator #(.N_ENTRIES(8), .N_RESERVED(0), .POLICY(2)) u_rr (
      .clk(clk), .rst_n(rst_n), .flush(fl[1]), .alloc_req(rq[1]), .alloc_valid(av1), .alloc_idx(ai1),
      .free_valid(fv[1]), .free_idx(fi[1][2:0]), .free_count(fc1), .double_free_err(er1));
   free_list_allocator #(.N_ENTRIES(12), .N_RESERVED(2), .POLICY(1)) u_hi (
      .clk(clk), .rst_n(rst_n), .flush(fl[2]), .alloc_req(rq[2]), .alloc_valid(av2), .alloc_idx(ai2),
      .free_valid(fv[2]), .free_idx(fi[2][3:0]), .free_count(fc2), .double_free_err(er2));
   function automatic int nn(int k);
      return (k == 0) ? 32 : (k == 1) ? 8 : 12;
   endfunction
   function automatic int nr(int k);
      return (k == 0) ? 8 : (k == 1) ? 0 : 2;
   endfunction
   function automatic int pol(int k);
      return (k == 0) ? 0 : (k == 1) ? 2 : 1;
   endfunction
   function automatic int iw_max(int k);
      return (k == 0) ? 31 : (k == 1) ? 7 : 15;
   endfunction
   function automatic mdl_t m_reset(int k);
      mdl_t r;
      r.map = '0;
      for (int i = nr(k); i < nn(k); i++) r.map[i] = 1'b1;
      r.rr = 0;
      r.err = 1'b0;
      return r;
   endfunction
   function automatic int m_sel(mdl_t s, int k);
      int n = nn(k);
      if (pol(k) == 0) begin
         for (int i = 0; i < n; i++) if (s.map[i]) return i;
      end else if (pol(k) == 1) begin
         for (int i = n - 1; i >= 0; i--) if (s.map[i]) return i;
      end else begin
         for (int i = 0; i < n; i++) if (s.map[(s.rr + i) % n]) return (s.rr + i) % n;
      end
      return -1;
   endfunction
   function automatic mdl_t m_step(mdl_t s, int k, bit f, bit req, bit v, int idx);
      mdl_t r = s;
      int g = m_sel(s, k);
      bit legal = v && idx < nn(k) && !s.map[idx];
      if (f) return m_reset(k);
      if (req && g >= 0) begin
         r.map[g] = 1'b0;
         if (pol(k) == 2) r.rr = (g + 1) % nn(k);
      end
      if (legal) r.map[idx] = 1'b1;
      r.err = v && !legal;
      return r;
   endfunction
   task automatic chk(string tag, int got, int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   task automatic check_all(string tag);
      int av, ai, fc, er, s;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: begin av = int'(av0); ai = int'(ai0); fc = int'(fc0); er = int'(er0); end
            1: begin av = int'(av1); ai = int'(ai1); fc = int'(fc1); er = int'(er1); end
            default: begin av = int'(av2); ai = int'(ai2); fc = int'(fc2); er = int'(er2); end
         endcase
         s = m_sel(m[k], k);
         chk($sformatf("%s d%0d valid", tag, k), av, (s >= 0) ? 1 : 0);
         chk($sformatf("%s d%0d idx", tag, k), ai, (s >= 0) ? s : 0);
         chk($sformatf("%s d%0d count", tag, k), fc, $countones(m[k].map));
         chk($sformatf("%s d%0d err", tag, k), er, int'(m[k].err));
      end
   endtask
   task automatic idle();
      for (int k = 0; k < 3; k++) begin
         fl[k] = 1'b0; rq[k] = 1'b0; fv[k] = 1'b0; fi[k] = '0;
      end
   endtask
   task automatic cyc(string tag);
      @(posedge clk);
      for (int k = 0; k < 3; k++) m[k] = m_step(m[k], k, fl[k], rq[k], fv[k], int'(fi[k]));
      #1;
      check_all(tag);
   endtask
   initial begin
      idle();
      for (int k = 0; k < 3; k++) m[k] = m_reset(k);
      #12;
      check_all("reset");
      chk("reset idx", int'(ai0), 8);
      chk("reset count", int'(fc0), 24);
      chk("reset valid", int'(av0), 1);
      chk("reset err", int'(er0), 0);
      rst_n = 1'b1;
      rq[0] = 1'b1;
      for (int i = 0; i < 24; i++) begin
         chk("lo seq idx", int'(ai0), 8 + i);
         cyc("lo drain");
      end
      chk("lo empty valid", int'(av0), 0);
      chk("lo empty count", int'(fc0), 0);
      cyc("lo req when empty");
      idle();
      fv[0] = 1'b1; fi[0] = 8'd5;
      cyc("lo free 5");
      idle();
      chk("lo refill idx", int'(ai0), 5);
      rq[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rr first", int'(ai1), i);
         cyc("rr grant");
      end
      idle();
      fv[1] = 1'b1; fi[1] = 8'd0;
      cyc("rr free 0");
      idle();
      rq[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("rr order", int'(ai1), (3 + i) % 8);
         cyc("rr wrap");
      end
      idle();
      fl[0] = 1'b1;
      cyc("lo flush");
      idle();
      rq[0] = 1'b1;
      cyc("lo grant 8");
      chk("lo offer 9", int'(ai0), 9);
      fv[0] = 1'b1; fi[0] = 8'd4;
      cyc("lo alloc+free");
      chk("lo alloc+free count", int'(fc0), 23);
      chk("lo alloc+free idx", int'(ai0), 4);
      rq[0] = 1'b0;
      cyc("lo double free");
      chk("lo double free err", int'(er0), 1);
      chk("lo double free count", int'(fc0), 23);
      idle();
      cyc("lo err clears");
      chk("lo err pulse", int'(er0), 0);
      rq[0] = 1'b1; fv[0] = 1'b1; fi[0] = 8'd4;
      cyc("lo free granted");
      chk("lo free granted err", int'(er0), 1);
      chk("lo free granted count", int'(fc0), 22);
      chk("lo free granted idx", int'(ai0), 10);
      idle();
      fv[2] = 1'b1; fi[2] = 8'd13;
      cyc("hi out of range");
      chk("hi oor err", int'(er2), 1);
      chk("hi oor count", int'(fc2), 10);
      idle();
      rq[0] = 1'b1;
      for (int i = 0; i < 8; i++) cyc("lo half");
      fl[0] = 1'b1; fv[0] = 1'b1; fi[0] = 8'd3;
      cyc("lo flush busy");
      chk("flush idx", int'(ai0), 8);
      chk("flush count", int'(fc0), 24);
      chk("flush err", int'(er0), 0);
      idle();
      for (int k = 0; k < 3; k++) rq[k] = 1'b1;
      for (int i = 0; i < 3; i++) cyc("burst");
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) m[k] = m_reset(k);
      check_all("async reset");
      chk("async count", int'(fc0), 24);
      #2;
      rst_n = 1'b1;
      idle();
      for (int i = 0; i < 2000; i++) begin
         for (int k = 0; k < 3; k++) begin
            fl[k] = ($urandom_range(0, 49) == 0);
            rq[k] = ($urandom_range(0, 9) < 6);
            fv[k] = ($urandom_range(0, 1) == 1);
            fi[k] = 8'($urandom_range(0, iw_max(k)));
         end
         cyc("rand");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
